// File: rtl/dram_ctrl_pkg.sv
// Shared state encodings, default timing constants and helpers for the DRAM controller slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dram_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_INIT       = 4'd0,
        ST_IDLE       = 4'd1,
        ST_ROW_SETUP  = 4'd2,
        ST_RCD        = 4'd3,
        ST_COL_SETUP  = 4'd4,
        ST_CAS        = 4'd5,
        ST_RELEASE    = 4'd6,
        ST_REF_SETUP  = 4'd7,
        ST_REF_RAS    = 4'd8,
        ST_PRECHARGE  = 4'd9
    } state_t;

    // Default geometry and timing, reused by the bench and the SIMM top level.
    localparam int DEF_RASBITS        = 8;
    localparam int DEF_WORDBITS       = 8;
    localparam int DEF_T_RCD          = 1;
    localparam int DEF_T_CAS          = 1;
    localparam int DEF_T_RAS          = 2;
    localparam int DEF_T_RP           = 1;
    localparam int DEF_REFRESH_PERIOD = 64;
    localparam int DEF_INIT_CYCLES    = 8;

    // Width of the per-phase cycle counter; every timing parameter must fit.
    localparam int CNT_W = 8;

    // A phase lasting N cycles loads N-1 and exits on the edge where the count is zero.
    function automatic logic [CNT_W-1:0] cyc_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/dram_ctrl_if.sv
// Host request/response stream plus the DRAM pin bundle of the controller.
// Latency: n/a (wiring only).
// Backpressure: host holds req_valid until req_ready; responses are unthrottled pulses.
interface dram_ctrl_if #(
    parameter int RASBITS  = 8,
    parameter int WORDBITS = 8
) ();
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [2*RASBITS-1:0]   req_addr;
    logic [WORDBITS-1:0]    req_wdata;
    logic                   rsp_valid;
    logic [WORDBITS-1:0]    rsp_rdata;
    logic                   dram_n_ras;
    logic                   dram_n_cas;
    logic                   dram_n_we;
    logic [RASBITS-1:0]     dram_ra;
    logic [WORDBITS-1:0]    dram_dq_out;
    logic                   dram_dq_oe;
    logic [WORDBITS-1:0]    dram_dq_in;
    logic                   refresh_overrun;

    // Host plus DRAM-pad side of the bundle.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, dram_dq_in,
        input  req_ready, rsp_valid, rsp_rdata, dram_n_ras, dram_n_cas, dram_n_we,
               dram_ra, dram_dq_out, dram_dq_oe, refresh_overrun
    );

    // Controller side of the bundle.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, dram_dq_in,
        output req_ready, rsp_valid, rsp_rdata, dram_n_ras, dram_n_cas, dram_n_we,
               dram_ra, dram_dq_out, dram_dq_oe, refresh_overrun
    );
endinterface

// File: rtl/dram_refresh_timer.sv
// Refresh interval down-counter with a single owed-refresh flag and a sticky overrun flag.
// Latency: pending rises REFRESH_PERIOD cycles after enable goes high, then every REFRESH_PERIOD cycles.
// Backpressure: at most one refresh is owed; an expiry while one is already owed sets overrun.
module dram_refresh_timer #(
    parameter int REFRESH_PERIOD = 64
) (
    input  logic clk,
    input  logic n_res,
    input  logic enable,
    input  logic ack,
    output logic pending,
    output logic overrun
);
    localparam int            TW     = $clog2(REFRESH_PERIOD);
    localparam logic [TW-1:0] RELOAD = TW'(REFRESH_PERIOD - 1);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          pending_q, pending_d;
    logic          overrun_q, overrun_d;

    // Count down while enabled; hold the reload value and drop any owed refresh while disabled.
    always_comb begin
        cnt_d     = cnt_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (!enable) begin
            cnt_d     = RELOAD;
            pending_d = 1'b0;
        end else if (cnt_q == '0) begin
            cnt_d     = RELOAD;
            // An ack on the expiry edge consumes the old request, so this is not an overrun.
            if (pending_q && !ack) begin
                overrun_d = 1'b1;
            end
            pending_d = 1'b1;
        end else begin
            cnt_d = cnt_q - TW'(1);
            if (ack) begin
                pending_d = 1'b0;
            end
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or negedge n_res) begin
        if (!n_res) begin
            cnt_q     <= RELOAD;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/dram_ctrl.sv
// Single-port async-DRAM controller: host valid/ready requests to muxed row/col address and RAS/CAS/WE strobes, with init and RAS-only refresh.
// Latency: read data pulses rsp_valid at E2+T_RCD+T_CAS after acceptance; controller idle again T_RP cycles after RAS release.
// Backpressure: req_ready only in IDLE with no refresh owed; a pending refresh always wins over a new request.
module dram_ctrl
    import dram_ctrl_pkg::*;
#(
    parameter int RASBITS        = DEF_RASBITS,
    parameter int WORDBITS       = DEF_WORDBITS,
    parameter int T_RCD          = DEF_T_RCD,
    parameter int T_CAS          = DEF_T_CAS,
    parameter int T_RAS          = DEF_T_RAS,
    parameter int T_RP           = DEF_T_RP,
    parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD,
    parameter int INIT_CYCLES    = DEF_INIT_CYCLES
) (
    input  logic       clk,
    input  logic       n_res,
    dram_ctrl_if.slave bus
);
    localparam int IW = $clog2(INIT_CYCLES + 2);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]        init_left_q, init_left_d;
    logic                 init_done_q, init_done_d;
    logic [RASBITS-1:0]   ref_row_q, ref_row_d;

    logic                 we_q, we_d;
    logic [RASBITS-1:0]   col_q, col_d;
    logic [WORDBITS-1:0]  wdata_q, wdata_d;

    logic                 n_ras_q, n_ras_d;
    logic                 n_cas_q, n_cas_d;
    logic                 n_we_q, n_we_d;
    logic [RASBITS-1:0]   ra_q, ra_d;
    logic [WORDBITS-1:0]  dq_out_q, dq_out_d;
    logic                 dq_oe_q, dq_oe_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [WORDBITS-1:0]  rsp_rdata_q, rsp_rdata_d;

    logic                 ref_pending;
    logic                 ref_overrun;
    logic                 ref_ack;
    logic                 cnt_zero;

    assign cnt_zero = (cnt_q == '0);
    assign ref_ack  = (state_q == ST_IDLE) && ref_pending;

    dram_refresh_timer #(
        .REFRESH_PERIOD (REFRESH_PERIOD)
    ) u_timer (
        .clk     (clk),
        .n_res   (n_res),
        .enable  (init_done_q),
        .ack     (ref_ack),
        .pending (ref_pending),
        .overrun (ref_overrun)
    );

    // State, phase counter and init bookkeeping registers.
    always_ff @(posedge clk or negedge n_res) begin
        if (!n_res) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_left_q <= IW'(INIT_CYCLES);
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_left_q <= init_left_d;
            init_done_q <= init_done_d;
        end
    end

    // Next-state sequencing; each timed phase loads its length on entry and exits at zero.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_left_d = init_left_q;
        case (state_q)
            ST_INIT: begin
                if (init_left_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d     = ST_REF_SETUP;
                    init_left_d = init_left_q - IW'(1);
                end
            end
            ST_IDLE: begin
                if (ref_pending)        state_d = ST_REF_SETUP;
                else if (bus.req_valid) state_d = ST_ROW_SETUP;
            end
            ST_ROW_SETUP: begin
                state_d = ST_RCD;
                cnt_d   = cyc_load(T_RCD);
            end
            ST_RCD: begin
                if (cnt_zero) state_d = ST_COL_SETUP;
                else          cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_COL_SETUP: begin
                state_d = ST_CAS;
                cnt_d   = cyc_load(T_CAS);
            end
            ST_CAS: begin
                if (cnt_zero) state_d = ST_RELEASE;
                else          cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_RELEASE: begin
                state_d = ST_PRECHARGE;
                cnt_d   = cyc_load(T_RP);
            end
            ST_REF_SETUP: begin
                state_d = ST_REF_RAS;
                cnt_d   = cyc_load(T_RAS);
            end
            ST_REF_RAS: begin
                if (cnt_zero) begin
                    state_d = ST_PRECHARGE;
                    cnt_d   = cyc_load(T_RP);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PRECHARGE: begin
                // Init refreshes run back to back; afterwards precharge always returns to IDLE.
                if (cnt_zero) state_d = (init_left_q != '0) ? ST_INIT : ST_IDLE;
                else          cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_INIT;
        endcase
        init_done_d = init_done_q | (state_d == ST_IDLE);
    end

    // Next values of the DRAM pins, latched request fields and response, per state.
    always_comb begin
        we_d        = we_q;
        col_d       = col_q;
        wdata_d     = wdata_q;
        ref_row_d   = ref_row_q;
        n_ras_d     = n_ras_q;
        n_cas_d     = n_cas_q;
        n_we_d      = n_we_q;
        ra_d        = ra_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = dq_oe_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_INIT: begin
                if (init_left_q != '0) ra_d = ref_row_q;
            end
            ST_IDLE: begin
                if (ref_pending) begin
                    ra_d = ref_row_q;
                end else if (bus.req_valid) begin
                    ra_d    = bus.req_addr[2*RASBITS-1:RASBITS];
                    col_d   = bus.req_addr[RASBITS-1:0];
                    we_d    = bus.req_we;
                    wdata_d = bus.req_wdata;
                end
            end
            ST_ROW_SETUP: n_ras_d = 1'b0;
            ST_RCD: begin
                // Column goes out a full cycle before CAS falls, so address never moves with a strobe.
                if (cnt_zero) begin
                    ra_d     = col_q;
                    n_we_d   = ~we_q;
                    dq_oe_d  = we_q;
                    dq_out_d = wdata_q;
                end
            end
            ST_COL_SETUP: n_cas_d = 1'b0;
            ST_CAS: begin
                if (cnt_zero) begin
                    n_cas_d = 1'b1;
                    if (!we_q) begin
                        rsp_rdata_d = bus.dram_dq_in;
                        rsp_valid_d = 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                // dq_oe is held through the CAS rise because that is where the SIMM captures write data.
                n_ras_d     = 1'b1;
                n_we_d      = 1'b1;
                dq_oe_d     = 1'b0;
                rsp_valid_d = 1'b0;
            end
            ST_REF_SETUP: n_ras_d = 1'b0;
            ST_REF_RAS: begin
                if (cnt_zero) begin
                    n_ras_d   = 1'b1;
                    ref_row_d = ref_row_q + RASBITS'(1);
                end
            end
            default: ;
        endcase
    end

    // Registered DRAM pins, request latch and response; everything off-chip is glitch-free.
    always_ff @(posedge clk or negedge n_res) begin
        if (!n_res) begin
            we_q        <= 1'b0;
            col_q       <= '0;
            wdata_q     <= '0;
            ref_row_q   <= '0;
            n_ras_q     <= 1'b1;
            n_cas_q     <= 1'b1;
            n_we_q      <= 1'b1;
            ra_q        <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            we_q        <= we_d;
            col_q       <= col_d;
            wdata_q     <= wdata_d;
            ref_row_q   <= ref_row_d;
            n_ras_q     <= n_ras_d;
            n_cas_q     <= n_cas_d;
            n_we_q      <= n_we_d;
            ra_q        <= ra_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready       = (state_q == ST_IDLE) && !ref_pending;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_rdata       = rsp_rdata_q;
    assign bus.dram_n_ras      = n_ras_q;
    assign bus.dram_n_cas      = n_cas_q;
    assign bus.dram_n_we       = n_we_q;
    assign bus.dram_ra         = ra_q;
    assign bus.dram_dq_out     = dq_out_q;
    assign bus.dram_dq_oe      = dq_oe_q;
    assign bus.refresh_overrun = ref_overrun;

endmodule

// File: tb/tb_dram_ctrl.sv
// Directed bench: default controller against a behavioural DRAM, plus a narrow-row instance and a fast-refresh instance.
// Latency: n/a.
// Backpressure: host side waits on req_ready with a bounded loop.
module tb_dram_ctrl;
    import dram_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic n_res = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    dram_ctrl_if #(.RASBITS(8), .WORDBITS(8)) m_if ();
    dram_ctrl_if #(.RASBITS(2), .WORDBITS(8)) w_if ();
    dram_ctrl_if #(.RASBITS(8), .WORDBITS(8)) o_if ();

    dram_ctrl #(.RASBITS(8), .WORDBITS(8)) u_dut (
        .clk(clk), .n_res(n_res), .bus(m_if.slave));
    dram_ctrl #(.RASBITS(2), .WORDBITS(8), .INIT_CYCLES(2), .REFRESH_PERIOD(8)) u_wrap (
        .clk(clk), .n_res(n_res), .bus(w_if.slave));
    dram_ctrl #(.RASBITS(8), .WORDBITS(8), .REFRESH_PERIOD(4)) u_ovr (
        .clk(clk), .n_res(n_res), .bus(o_if.slave));

    // Behavioural DRAM for the main instance.
    logic [7:0] mem [0:65535];
    logic [7:0] row_l;
    logic [7:0] col_l;
    logic [7:0] ras_log [$];
    int         cas_falls = 0;
    int         rsp_cnt   = 0;

    always @(negedge m_if.dram_n_ras) begin
        row_l = m_if.dram_ra;
        ras_log.push_back(m_if.dram_ra);
    end
    always @(negedge m_if.dram_n_cas) begin
        cas_falls++;
        col_l = m_if.dram_ra;
        m_if.dram_dq_in = mem[{row_l, m_if.dram_ra}];
    end
    always @(posedge m_if.dram_n_cas) begin
        if (!m_if.dram_n_we && m_if.dram_dq_oe) mem[{row_l, col_l}] = m_if.dram_dq_out;
    end
    always @(negedge clk) begin
        if (m_if.rsp_valid === 1'b1) rsp_cnt++;
    end

    // Narrow-row instance: idle host, record refresh rows.
    logic [1:0] w_log [$];
    initial begin
        w_if.req_valid = 1'b0; w_if.req_we = 1'b0; w_if.req_addr = '0;
        w_if.req_wdata = '0;   w_if.dram_dq_in = '0;
    end
    always @(negedge w_if.dram_n_ras) w_log.push_back(w_if.dram_ra);

    // Fast-refresh instance: host keeps requesting reads.
    int o_ref_cnt  = 0;
    int o_rsp_cnt  = 0;
    bit o_cas_seen = 1'b1;
    initial begin
        o_if.req_valid = 1'b1; o_if.req_we = 1'b0; o_if.req_addr = 16'h0102;
        o_if.req_wdata = '0;   o_if.dram_dq_in = 8'h00;
    end
    always @(negedge o_if.dram_n_ras) o_cas_seen = 1'b0;
    always @(negedge o_if.dram_n_cas) o_cas_seen = 1'b1;
    always @(posedge o_if.dram_n_ras) begin
        if (!o_cas_seen) o_ref_cnt++;
    end
    always @(negedge clk) begin
        if (o_if.rsp_valid === 1'b1) o_rsp_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (m_if.req_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, m_if.req_ready, 1);
    endtask

    // Present a request at a negedge and return at the negedge after the accepting edge.
    task automatic issue(input logic we, input logic [15:0] addr, input logic [7:0] wd, input string tag);
        m_if.req_valid = 1'b1;
        m_if.req_we    = we;
        m_if.req_addr  = addr;
        m_if.req_wdata = wd;
        wait_ready({tag, "_accept"});
        @(posedge clk);
        @(negedge clk);
        m_if.req_valid = 1'b0;
    endtask

    // Cycle-by-cycle access shape, starting at the negedge after E0.
    task automatic check_access(input logic we, input logic [15:0] addr, input logic [7:0] d, input string tag);
        chk({tag, "_c0_ra_row"}, m_if.dram_ra, addr[15:8]);
        chk({tag, "_c0_ras_ready"}, {m_if.dram_n_ras, m_if.req_ready}, 2'b10);
        @(negedge clk);
        chk({tag, "_c1_ras_low"}, {m_if.dram_n_ras, m_if.dram_n_cas, m_if.dram_ra}, {2'b01, addr[15:8]});
        @(negedge clk);
        chk({tag, "_c2_col"}, m_if.dram_ra, addr[7:0]);
        chk({tag, "_c2_we_oe_cas"}, {m_if.dram_n_we, m_if.dram_dq_oe, m_if.dram_n_cas}, {!we, we, 1'b1});
        if (we) chk({tag, "_c2_dq_out"}, m_if.dram_dq_out, d);
        @(negedge clk);
        chk({tag, "_c3_cas_low"}, {m_if.dram_n_ras, m_if.dram_n_cas}, 2'b00);
        @(negedge clk);
        chk({tag, "_c4_cas_rise"}, {m_if.dram_n_cas, m_if.dram_dq_oe, m_if.rsp_valid}, {1'b1, we, !we});
        if (!we) chk({tag, "_c4_rdata"}, m_if.rsp_rdata, d);
        @(negedge clk);
        chk({tag, "_c5_release"}, {m_if.dram_n_ras, m_if.dram_n_we, m_if.dram_dq_oe, m_if.rsp_valid}, 4'b1100);
        @(negedge clk);
        chk({tag, "_c6_ready"}, m_if.req_ready, 1);
    endtask

    initial begin
        logic [1:0] exp_w [7];
        int n;
        int r1;
        int snap_rsp;
        int snap_cas;
        exp_w = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        m_if.req_valid = 1'b0;
        m_if.req_we    = 1'b0;
        m_if.req_addr  = '0;
        m_if.req_wdata = '0;

        // Reset values.
        #1 n_res = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_strobes", {m_if.dram_n_ras, m_if.dram_n_cas, m_if.dram_n_we, m_if.dram_dq_oe}, 4'b1110);
        chk("rst_ra_dq", {m_if.dram_ra, m_if.dram_dq_out, m_if.rsp_rdata}, 24'h0);
        chk("rst_flags", {m_if.req_ready, m_if.rsp_valid, m_if.refresh_overrun, o_if.refresh_overrun}, 4'b0000);
        n_res = 1'b1;

        // Power-up refreshes: rows 0..7, CAS never falls, ready only afterwards.
        wait_ready("init_ready");
        chk("init_ras_count", ras_log.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("init_row%0d", i), ras_log[i], i);
        chk("init_no_cas", cas_falls, 0);
        chk("init_ras_high_at_ready", m_if.dram_n_ras, 1);

        // Write then read back.
        issue(1'b1, 16'h1234, 8'hA5, "wr");
        check_access(1'b1, 16'h1234, 8'hA5, "wr");
        issue(1'b0, 16'h1234, 8'h00, "rd");
        check_access(1'b0, 16'h1234, 8'hA5, "rd");
        chk("rd_single_rsp", rsp_cnt, 1);

        // Request arriving as a refresh becomes owed: refresh row 8 goes first.
        n = 0;
        while (u_dut.ref_pending !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("col_pending", u_dut.ref_pending, 1);
        m_if.req_valid = 1'b1;
        m_if.req_we    = 1'b0;
        m_if.req_addr  = 16'h1234;
        @(negedge clk);
        chk("col_ref_row", {m_if.dram_ra, m_if.dram_n_ras, m_if.req_ready}, {8'd8, 2'b10});
        @(negedge clk);
        chk("col_ref_ras_low", {m_if.dram_n_ras, m_if.dram_n_cas}, 2'b01);
        @(negedge clk);
        @(negedge clk);
        chk("col_ref_ras_high", m_if.dram_n_ras, 1);
        @(negedge clk);
        chk("col_ready_after_pre", m_if.req_ready, 1);
        @(negedge clk);
        m_if.req_valid = 1'b0;
        check_access(1'b0, 16'h1234, 8'hA5, "col");

        // Narrow-row instance refresh rows wrap 3 -> 0.
        chk("wrap_log_len", w_log.size() >= 7, 1);
        for (int i = 0; i < 7; i++) chk($sformatf("wrap_row%0d", i), w_log[i], exp_w[i]);

        // Fast refresh with continuous requests: sticky overrun, refresh still serviced.
        chk("ovr_set", o_if.refresh_overrun, 1);
        chk("ovr_first_access_done", o_rsp_cnt > 0, 1);
        r1 = o_ref_cnt;
        repeat (40) @(negedge clk);
        chk("ovr_sticky", o_if.refresh_overrun, 1);
        chk("ovr_refresh_serviced", o_ref_cnt > r1, 1);
        chk("main_no_overrun", m_if.refresh_overrun, 0);

        // Reset while CAS is low during a write.
        snap_rsp = rsp_cnt;
        issue(1'b1, 16'h5678, 8'h3C, "rw");
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rw_cas_low", m_if.dram_n_cas, 0);
        #2 n_res = 1'b0;
        #1;
        chk("rw_async_strobes", {m_if.dram_n_ras, m_if.dram_n_cas, m_if.dram_n_we, m_if.dram_dq_oe}, 4'b1110);
        ras_log.delete();
        snap_cas = cas_falls;
        @(negedge clk);
        @(negedge clk);
        n_res = 1'b1;
        wait_ready("rw_reinit_ready");
        chk("rw_reinit_count", ras_log.size(), 8);
        chk("rw_reinit_row0", ras_log[0], 0);
        chk("rw_reinit_row7", ras_log[7], 7);
        chk("rw_no_rsp", rsp_cnt, snap_rsp);
        chk("rw_no_cas", cas_falls, snap_cas);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
